enc_64b: RTL and testbench

- Pipelined 64-bit priority encoder; the inverse of the 6-to-64 one-hot decoder in the math library.
- Converts a 64-bit vector into the 6-bit index of its priority set bit, plus a zero flag.
- Valid/ready handshake on both sides, so it can sit between streaming math blocks with backpressure.
- A one-hot input round-trips exactly through dec_64b.

---
 rtl/enc_64b.sv | 109 ++++++++++
 tb/tb_enc_64b.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_64b.sv
// Pipelined 64-bit priority encoder with valid/ready handshake on both sides.
// Stage 1 resolves priority within each byte; stage 2 selects the winning byte.
module enc_64b #(
    parameter int REG_OUT   = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [5:0]  out_data_o,
    output logic        out_zero_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    logic [7:0]       grp_hit_d;
    logic [7:0][2:0]  grp_idx_d;
    logic [7:0]       s1_hit_q;
    logic [7:0][2:0]  s1_idx_q;
    logic             s1_valid_q;
    logic             s1_load;
    logic [2:0]       win_grp;
    logic [5:0]       out_data_d;
    logic             out_zero_d;

    always_comb begin
        grp_hit_d = '0;
        grp_idx_d = '0;
        for (int g = 0; g < 8; g++) begin
            grp_hit_d[g] = |in_data_i[8*g +: 8];
            for (int b = 0; b < 8; b++) begin
                if (LSB_FIRST != 0) begin
                    if (in_data_i[8*g + (7 - b)]) grp_idx_d[g] = 3'(7 - b);
                end else begin
                    if (in_data_i[8*g + b]) grp_idx_d[g] = 3'(b);
                end
            end
        end
    end

    // Data regs only move on a real capture; the valid flag follows every load slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= '0;
            s1_idx_q   <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_hit_q <= grp_hit_d;
                s1_idx_q <= grp_idx_d;
            end
        end
    end

    always_comb begin
        win_grp = '0;
        for (int g = 0; g < 8; g++) begin
            if (LSB_FIRST != 0) begin
                if (s1_hit_q[7 - g]) win_grp = 3'(7 - g);
            end else begin
                if (s1_hit_q[g]) win_grp = 3'(g);
            end
        end
        out_zero_d = ~|s1_hit_q;
        out_data_d = out_zero_d ? 6'd0 : {win_grp, s1_idx_q[win_grp]};
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic       s2_valid_q;
            logic [5:0] s2_data_q;
            logic       s2_zero_q;
            logic       s2_load;

            assign s2_load = !s2_valid_q || out_ready_i;
            assign s1_load = !s1_valid_q || s2_load;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                    s2_zero_q  <= 1'b0;
                end else if (s2_load) begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= out_data_d;
                        s2_zero_q <= out_zero_d;
                    end
                end
            end

            assign out_valid_o = s2_valid_q;
            assign out_data_o  = s2_data_q;
            assign out_zero_o  = s2_zero_q;
        end else begin : g_comb_out
            assign s1_load     = !s1_valid_q || out_ready_i;
            assign out_valid_o = s1_valid_q;
            assign out_data_o  = out_data_d;
            // Empty stage-1 regs look like an all-zero vector; mask so idle zero stays low.
            assign out_zero_o  = s1_valid_q & out_zero_d;
        end
    endgenerate

    assign in_ready_o = s1_load;

endmodule

// File: tb/tb_enc_64b.sv
// Bench for enc_64b: four instances (REG_OUT x LSB_FIRST) share stimulus, each
// tracked by a queue model of in-flight items with acceptance times.
module tb_enc_64b;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready  [4];
    logic [5:0]  out_data  [4];
    logic        out_zero  [4];
    logic        out_valid [4];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    logic [5:0] q_data [4][4];
    logic       q_zero [4][4];
    int         q_acc  [4][4];
    int         head [4];
    int         cnt  [4];
    int         dut_outs [4];
    int         first_out [4];

    localparam logic [63:0] DV [6] = '{64'h8000_0000_0000_0001, 64'h0000_0100_0010_0000,
                                       64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                                       64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};
    localparam int EXP_HI [6] = '{63, 40, 63, 0, 0, 63};
    localparam int EXP_LO [6] = '{0, 20, 0, 0, 0, 63};
    localparam int EXP_Z  [6] = '{0, 0, 0, 1, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        enc_64b #(.REG_OUT((g < 2) ? 1 : 0), .LSB_FIRST(g % 2)) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .in_data_i  (in_data),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready[g]),
            .out_data_o (out_data[g]),
            .out_zero_o (out_zero[g]),
            .out_valid_o(out_valid[g]),
            .out_ready_i(out_ready)
        );
    end

    function automatic bit is_reg(input int k);
        return k < 2;
    endfunction

    function automatic bit is_lsb(input int k);
        return (k % 2) != 0;
    endfunction

    // {zero, index} straight from the definition: scan every bit.
    function automatic logic [6:0] ref_enc(input logic [63:0] v, input bit lsb);
        int idx;
        idx = -1;
        for (int i = 0; i < 64; i++)
            if (v[i] && (idx < 0 || !lsb)) idx = i;
        if (idx < 0) return {1'b1, 6'd0};
        return {1'b0, 6'(idx)};
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d at cycle %0d", name, k, act, exp, cyc);
        end
    endtask

    task automatic model_cmp();
        int  depth;
        int  slot;
        bit  exp_rdy;
        bit  exp_vld;
        logic [6:0] r;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                cnt[k]  = 0;
                head[k] = 0;
            end else begin
                depth   = is_reg(k) ? 2 : 1;
                exp_rdy = (cnt[k] < depth) || out_ready;
                exp_vld = (cnt[k] > 0) && (cyc - q_acc[k][head[k]] >= (is_reg(k) ? 1 : 0));
                chk("in_ready", k, 64'(in_ready[k]), 64'(exp_rdy));
                chk("out_valid", k, 64'(out_valid[k]), 64'(exp_vld));
                if (exp_vld) begin
                    chk("out_data", k, 64'(out_data[k]), 64'(q_data[k][head[k]]));
                    chk("out_zero", k, 64'(out_zero[k]), 64'(q_zero[k][head[k]]));
                end
                if (out_valid[k] && first_out[k] < 0) first_out[k] = cyc;
                if (out_valid[k] && out_ready) dut_outs[k]++;
                if (exp_vld && out_ready) begin
                    head[k] = (head[k] + 1) % 4;
                    cnt[k]--;
                end
                if (in_valid && exp_rdy) begin
                    slot = (head[k] + cnt[k]) % 4;
                    r = ref_enc(in_data, is_lsb(k));
                    q_data[k][slot] = r[5:0];
                    q_zero[k][slot] = r[6];
                    q_acc[k][slot]  = cyc + 1;
                    cnt[k]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cmp();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_vec();
        logic [63:0] v;
        case ($urandom_range(3))
            0: v = {$urandom(), $urandom()};
            1: v = 64'd1 << $urandom_range(63);
            2: v = {$urandom(), $urandom()} & {$urandom(), $urandom()} &
                   {$urandom(), $urandom()} & {$urandom(), $urandom()};
            default: v = ($urandom_range(1) != 0) ? 64'd0 : ~64'd0;
        endcase
        return v;
    endfunction

    // Source holds its item until instance 0 takes it; the other instances may
    // drop or repeat items, which the model tracks from their own handshakes.
    task automatic run_random(input int n);
        logic acc0;
        acc0 = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (!in_valid || acc0) begin
                in_valid = 1'($urandom_range(1));
                in_data  = rand_vec();
            end
            out_ready = 1'($urandom_range(1));
            #1;
            acc0 = in_valid && in_ready[0];
            step();
        end
    endtask

    initial begin
        int c0;
        int base [4];
        int sent;
        int base0;
        logic acc0;

        for (int k = 0; k < 4; k++) begin
            head[k] = 0; cnt[k] = 0; dut_outs[k] = 0; first_out[k] = -1;
        end

        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_valid", k, 64'(out_valid[k]), 64'd0);
            chk("rst_data", k, 64'(out_data[k]), 64'd0);
            chk("rst_zero", k, 64'(out_zero[k]), 64'd0);
        end
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) chk("rst_ready", k, 64'(in_ready[k]), 64'd1);

        // one-hot sweep, back to back
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            first_out[k] = -1;
            base[k] = dut_outs[k];
        end
        c0 = cyc;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = 64'd1 << i;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("sweep_latency", 0, 64'(first_out[0] - c0), 64'd2);
        chk("sweep_latency", 2, 64'(first_out[2] - c0), 64'd1);
        for (int k = 0; k < 4; k++) chk("sweep_count", k, 64'(dut_outs[k] - base[k]), 64'd64);

        // round trip of decoder outputs in random order
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = 64'd1 << $urandom_range(63);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();

        // directed priority vectors, held at the output under stall
        for (int j = 0; j < 6; j++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = DV[j];
            step();
            in_valid = 1'b0;
            step();
            step();
            for (int k = 0; k < 4; k++) begin
                chk("dir_valid", k, 64'(out_valid[k]), 64'd1);
                chk("dir_data", k, 64'(out_data[k]), 64'(is_lsb(k) ? EXP_LO[j] : EXP_HI[j]));
                chk("dir_zero", k, 64'(out_zero[k]), 64'(EXP_Z[j]));
            end
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        step();

        // backpressure: 8 items, output stalled for cycles 3..7 after first accept
        sent  = 0;
        base0 = dut_outs[0];
        for (int t = 0; t < 30; t++) begin
            out_ready = !(t >= 3 && t <= 7);
            in_valid  = (sent < 8);
            in_data   = 64'd1 << ((sent * 7) % 64);
            #1;
            if (t == 7) begin
                chk("bp_ready_full", 0, 64'(in_ready[0]), 64'd0);
                chk("bp_ready_full", 2, 64'(in_ready[2]), 64'd0);
                chk("bp_hold_valid", 0, 64'(out_valid[0]), 64'd1);
            end
            acc0 = in_valid && in_ready[0];
            step();
            if (acc0) sent++;
        end
        chk("bp_count", 0, 64'(dut_outs[0] - base0), 64'd8);

        // random stress
        in_valid = 1'b0;
        run_random(20000);

        // reset mid-stream with every stage occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h0000_0040_0000_0100;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("midrst_valid", k, 64'(out_valid[k]), 64'd0);
            chk("midrst_data", k, 64'(out_data[k]), 64'd0);
            chk("midrst_zero", k, 64'(out_zero[k]), 64'd0);
        end
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) chk("midrst_ready", k, 64'(in_ready[k]), 64'd1);
        out_ready = 1'b1;
        repeat (5) step();
        run_random(200);

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
